// File: rtl/xadac_pkg.sv
// Shared types for the XADAC execute path: tags, immediates, vector/scalar data,
// register addresses and the entries carried through the issuer.
package xadac_pkg;

  localparam int unsigned VectorWidth    = 64;
  localparam int unsigned NrVRegsDefault = 32;

  typedef logic [7:0]                         id_t;
  typedef logic [31:0]                        imm_t;
  typedef logic [VectorWidth-1:0]             vec_t;
  typedef logic [31:0]                        reg_t;
  typedef logic [$clog2(NrVRegsDefault)-1:0]  vreg_addr_t;

  // What must be remembered about an issued op until its response retires.
  typedef struct packed {
    id_t        id;
    vreg_addr_t vd;
    logic       vd_we;
  } issue_entry_t;

  typedef struct packed {
    id_t        id;
    imm_t       imm;
    vreg_addr_t vs1;
    vreg_addr_t vs2;
    vreg_addr_t vs3;
    vreg_addr_t vd;
    logic       vd_we;
  } stage_b_t;

endpackage

// File: rtl/xadac_ex_if.sv
// Request/response channel between the XADAC issuer (master) and an execution unit (slave).
interface xadac_ex_if;
  import xadac_pkg::*;

  logic req_valid;
  logic req_ready;
  id_t  req_id;
  imm_t req_imm;
  vec_t req_vs1;
  vec_t req_vs2;
  vec_t req_vs3;

  logic resp_valid;
  logic resp_ready;
  id_t  resp_id;
  vec_t resp_vd;
  reg_t resp_rd;

  modport Master (
    output req_valid, req_id, req_imm, req_vs1, req_vs2, req_vs3, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );

  modport Slave (
    input  req_valid, req_id, req_imm, req_vs1, req_vs2, req_vs3, resp_ready,
    output req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );

endinterface

// File: rtl/xadac_issue_fifo.sv
// In-order tracking FIFO for issued ops. A push and pop in the same cycle while
// empty is a pass-through: the entry is consumed without ever being stored.
module xadac_issue_fifo
  import xadac_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  issue_entry_t               push_entry,
  input  logic                       pop,
  output issue_entry_t               peek,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  issue_entry_t          mem [Depth];
  logic [AddrW-1:0]      wptr;
  logic [AddrW-1:0]      rptr;
  logic [CntW-1:0]       count_q;
  logic                  write;
  logic                  advance;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count   = count_q;
  assign peek    = mem[rptr];
  assign write   = push && (!full || pop) && !(pop && empty);
  assign advance = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (write)   wptr <= wptr + 1'b1;
      if (advance) rptr <= rptr + 1'b1;
      unique case ({write, advance})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (write) mem[wptr] <= push_entry;
  end

endmodule

// File: rtl/xadac_ex_issuer.sv
// Master end of the XADAC execute interface: reads sources, issues ops in order,
// stalls on register hazards and retires responses into the VRF and scalar channel.
module xadac_ex_issuer
  import xadac_pkg::*;
#(
  parameter int unsigned NrVRegs        = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  id_t        in_id_i,
  input  imm_t       in_imm_i,
  input  vreg_addr_t in_vs1_i,
  input  vreg_addr_t in_vs2_i,
  input  vreg_addr_t in_vs3_i,
  input  vreg_addr_t in_vd_i,
  input  logic       in_vd_we_i,
  output vreg_addr_t vrf_raddr_o [3],
  input  vec_t       vrf_rdata_i [3],
  output logic       vrf_we_o,
  output vreg_addr_t vrf_waddr_o,
  output vec_t       vrf_wdata_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output id_t        out_id_o,
  output reg_t       out_rd_o,
  output logic       err_o,
  xadac_ex_if.Master mst
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

  stage_b_t           b_q;
  logic               b_valid_q;
  logic [NrVRegs-1:0] pending_q;
  logic [NrVRegs-1:0] pending_d;
  logic               err_q;

  logic               accept;
  logic               issue;
  logic               resp_accept;
  logic               hazard;
  logic               has_room;
  issue_entry_t       push_entry;
  issue_entry_t       peek;
  issue_entry_t       head;
  logic               head_valid;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CntW-1:0]    fifo_count;

  assign hazard   = pending_q[in_vs1_i] || pending_q[in_vs2_i] ||
                    pending_q[in_vs3_i] || pending_q[in_vd_i];
  // A pop in this cycle does not free a slot until the next one.
  assign has_room = (32'(fifo_count) + 32'(b_valid_q)) < MaxOutstanding;

  assign in_ready_o = (!b_valid_q || mst.req_ready) && has_room && !fifo_full && !hazard;
  assign accept     = in_valid_i && in_ready_o;
  assign issue      = b_valid_q && mst.req_ready;

  always_comb begin
    if (accept) begin
      vrf_raddr_o[0] = in_vs1_i;
      vrf_raddr_o[1] = in_vs2_i;
      vrf_raddr_o[2] = in_vs3_i;
    end else begin
      vrf_raddr_o[0] = b_q.vs1;
      vrf_raddr_o[1] = b_q.vs2;
      vrf_raddr_o[2] = b_q.vs3;
    end
  end

  assign mst.req_valid = b_valid_q;
  assign mst.req_id    = b_q.id;
  assign mst.req_imm   = b_q.imm;
  assign mst.req_vs1   = vrf_rdata_i[0];
  assign mst.req_vs2   = vrf_rdata_i[1];
  assign mst.req_vs3   = vrf_rdata_i[2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_q <= 1'b0;
      b_q       <= '0;
    end else if (accept) begin
      b_valid_q <= 1'b1;
      b_q       <= '{id: in_id_i, imm: in_imm_i, vs1: in_vs1_i, vs2: in_vs2_i,
                     vs3: in_vs3_i, vd: in_vd_i, vd_we: in_vd_we_i};
    end else if (issue) begin
      b_valid_q <= 1'b0;
    end
  end

  assign push_entry = '{id: b_q.id, vd: b_q.vd, vd_we: b_q.vd_we};

  xadac_issue_fifo #(
    .Depth (MaxOutstanding)
  ) i_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (issue),
    .push_entry (push_entry),
    .pop        (resp_accept),
    .peek       (peek),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // A zero-latency slave answers the op being pushed this cycle.
  assign head_valid = !fifo_empty || issue;
  assign head       = fifo_empty ? push_entry : peek;

  assign mst.resp_ready = out_ready_i && head_valid;
  assign out_valid_o    = mst.resp_valid && head_valid;
  assign resp_accept    = mst.resp_valid && mst.resp_ready;
  assign out_id_o       = head.id;
  assign out_rd_o       = mst.resp_rd;

  assign vrf_we_o    = resp_accept && head.vd_we;
  assign vrf_waddr_o = head.vd;
  assign vrf_wdata_o = mst.resp_vd;

  // Set beats clear when dispatch and retire touch the same register.
  always_comb begin
    pending_d = pending_q;
    if (resp_accept && head.vd_we) pending_d[head.vd] = 1'b0;
    if (accept && in_vd_we_i)      pending_d[in_vd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if ((resp_accept && (mst.resp_id != head.id)) || (mst.resp_valid && !head_valid))
        err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_xadac_ex_issuer.sv
// Directed bench for xadac_ex_issuer: the bench plays VRF and execution unit.
module tb_xadac_ex_issuer;
  import xadac_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  id_t        in_id;
  imm_t       in_imm;
  vreg_addr_t in_vs1, in_vs2, in_vs3, in_vd;
  logic       in_vd_we;
  vreg_addr_t vrf_raddr [3];
  vec_t       vrf_rdata [3];
  logic       vrf_we;
  vreg_addr_t vrf_waddr;
  vec_t       vrf_wdata;
  logic       out_valid;
  logic       out_ready;
  id_t        out_id;
  reg_t       out_rd;
  logic       err;

  logic       zl_mode;
  logic       s_req_ready;
  logic       s_resp_valid;
  id_t        s_resp_id;
  vec_t       s_resp_vd;
  reg_t       s_resp_rd;

  int total = 0;
  int bad   = 0;

  xadac_ex_if ex_if ();

  xadac_ex_issuer #(.NrVRegs(32), .MaxOutstanding(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_id_i     (in_id),
    .in_imm_i    (in_imm),
    .in_vs1_i    (in_vs1),
    .in_vs2_i    (in_vs2),
    .in_vs3_i    (in_vs3),
    .in_vd_i     (in_vd),
    .in_vd_we_i  (in_vd_we),
    .vrf_raddr_o (vrf_raddr),
    .vrf_rdata_i (vrf_rdata),
    .vrf_we_o    (vrf_we),
    .vrf_waddr_o (vrf_waddr),
    .vrf_wdata_o (vrf_wdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_id_o    (out_id),
    .out_rd_o    (out_rd),
    .err_o       (err),
    .mst         (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRF register r holds 0x100 + r; read data arrives one cycle after the address.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) vrf_rdata[k] <= 64'h100 + 64'(vrf_raddr[k]);
  end

  assign ex_if.req_ready = s_req_ready;

  // Zero-latency slave answers in the request cycle with vs1+vs2+vs3.
  always_comb begin
    if (zl_mode) begin
      ex_if.resp_valid = ex_if.req_valid;
      ex_if.resp_id    = ex_if.req_id;
      ex_if.resp_vd    = ex_if.req_vs1 + ex_if.req_vs2 + ex_if.req_vs3;
      ex_if.resp_rd    = 32'h1000 + 32'(ex_if.req_id);
    end else begin
      ex_if.resp_valid = s_resp_valid;
      ex_if.resp_id    = s_resp_id;
      ex_if.resp_vd    = s_resp_vd;
      ex_if.resp_rd    = s_resp_rd;
    end
  end

  task automatic drive_op(input id_t id, input vreg_addr_t vs1, vs2, vs3, vd, input logic we);
    in_valid = 1'b1;
    in_id    = id;
    in_imm   = 32'hA0 + 32'(id);
    in_vs1   = vs1;
    in_vs2   = vs2;
    in_vs3   = vs3;
    in_vd    = vd;
    in_vd_we = we;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_id = '0; in_imm = '0;
    in_vs1 = '0; in_vs2 = '0; in_vs3 = '0; in_vd = '0; in_vd_we = 1'b0;
    out_ready = 1'b1; zl_mode = 1'b0; s_req_ready = 1'b1;
    s_resp_valid = 1'b0; s_resp_id = '0; s_resp_vd = '0; s_resp_rd = '0;
    @(negedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0h want 1", in_ready); end
    total++; if (ex_if.req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid: got %0h want 0", ex_if.req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0h want 0", out_valid); end
    total++; if (vrf_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_vrf_we: got %0h want 0", vrf_we); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %0h want 0", err); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    zl_mode = 1'b1;
    @(negedge clk); drive_op(8'd5, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready: got %0h want 1", in_ready); end
    total++; if (vrf_raddr[0] !== 5'd1) begin bad++; $display("[TB] FAIL single_raddr0: got %0h want 1", vrf_raddr[0]); end
    @(negedge clk); in_valid = 1'b0; #1;
    total++; if (ex_if.req_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_req_valid: got %0h want 1", ex_if.req_valid); end
    total++; if (ex_if.req_vs1 !== 64'h101) begin bad++; $display("[TB] FAIL single_vs1: got %0h want 101", ex_if.req_vs1); end
    total++; if (ex_if.req_vs3 !== 64'h103) begin bad++; $display("[TB] FAIL single_vs3: got %0h want 103", ex_if.req_vs3); end
    total++; if (ex_if.req_imm !== 32'hA5) begin bad++; $display("[TB] FAIL single_imm: got %0h want a5", ex_if.req_imm); end
    total++; if (vrf_we !== 1'b1) begin bad++; $display("[TB] FAIL single_vrf_we: got %0h want 1", vrf_we); end
    total++; if (vrf_waddr !== 5'd4) begin bad++; $display("[TB] FAIL single_waddr: got %0h want 4", vrf_waddr); end
    total++; if (vrf_wdata !== 64'h306) begin bad++; $display("[TB] FAIL single_wdata: got %0h want 306", vrf_wdata); end
    total++; if (out_valid !== 1'b1 || out_id !== 8'd5) begin bad++; $display("[TB] FAIL single_out: got valid=%0h id=%0d want valid=1 id=5", out_valid, out_id); end
    total++; if (out_rd !== 32'h1005) begin bad++; $display("[TB] FAIL single_rd: got %0h want 1005", out_rd); end
    @(negedge clk); in_vs1 = 5'd4; #1;
    total++; if (ex_if.req_valid !== 1'b0 || vrf_we !== 1'b0) begin bad++; $display("[TB] FAIL single_idle: got req_valid=%0h vrf_we=%0h want 0 0", ex_if.req_valid, vrf_we); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_pending_clear: got %0h want 1", in_ready); end
    zl_mode = 1'b0;
  endtask

  task automatic test_raw();
    @(negedge clk); drive_op(8'd1, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL raw_a_ready: got %0h want 1", in_ready); end
    @(negedge clk); drive_op(8'd2, 5'd7, 5'd0, 5'd0, 5'd10, 1'b1); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL raw_stall1: got %0h want 0", in_ready); end
    @(negedge clk); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL raw_stall2: got %0h want 0", in_ready); end
    @(negedge clk); s_resp_valid = 1'b1; s_resp_id = 8'd1; s_resp_vd = 64'hBEEF; #1;
    total++; if (vrf_we !== 1'b1 || vrf_waddr !== 5'd7) begin bad++; $display("[TB] FAIL raw_a_write: got we=%0h waddr=%0d want 1 7", vrf_we, vrf_waddr); end
    total++; if (vrf_wdata !== 64'hBEEF) begin bad++; $display("[TB] FAIL raw_a_wdata: got %0h want beef", vrf_wdata); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL raw_stall_retire: got %0h want 0", in_ready); end
    @(negedge clk); s_resp_valid = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL raw_b_ready: got %0h want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    total++; if (ex_if.req_valid !== 1'b1 || ex_if.req_id !== 8'd2) begin bad++; $display("[TB] FAIL raw_b_issue: got valid=%0h id=%0d want 1 2", ex_if.req_valid, ex_if.req_id); end
    total++; if (ex_if.req_vs1 !== 64'h107) begin bad++; $display("[TB] FAIL raw_b_vs1: got %0h want 107", ex_if.req_vs1); end
    @(negedge clk); s_resp_valid = 1'b1; s_resp_id = 8'd2; #1;
    total++; if (vrf_we !== 1'b1 || vrf_waddr !== 5'd10) begin bad++; $display("[TB] FAIL raw_b_write: got we=%0h waddr=%0d want 1 10", vrf_we, vrf_waddr); end
    @(negedge clk); s_resp_valid = 1'b0;
  endtask

  task automatic test_capacity();
    logic exp_ready [6];
    exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_op((i < 4) ? id_t'(i + 1) : 8'd5, 5'd0, 5'd0, 5'd0, (i < 4) ? vreg_addr_t'(11 + i) : 5'd15, 1'b1);
      #1;
      total++; if (in_ready !== exp_ready[i]) begin bad++; $display("[TB] FAIL cap_ready%0d: got %0h want %0h", i, in_ready, exp_ready[i]); end
    end
    @(negedge clk); s_resp_valid = 1'b1; s_resp_id = 8'd1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL cap_no_credit: got %0h want 0", in_ready); end
    total++; if (vrf_waddr !== 5'd11 || out_id !== 8'd1) begin bad++; $display("[TB] FAIL cap_first_retire: got waddr=%0d id=%0d want 11 1", vrf_waddr, out_id); end
    @(negedge clk); s_resp_valid = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL cap_fifth_ready: got %0h want 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b0; s_resp_valid = 1'b1; s_resp_id = id_t'(2 + k); #1;
      total++; if (out_id !== id_t'(2 + k) || vrf_waddr !== vreg_addr_t'(12 + k)) begin bad++; $display("[TB] FAIL cap_drain%0d: got id=%0d waddr=%0d want %0d %0d", k, out_id, vrf_waddr, 2 + k, 12 + k); end
    end
    @(negedge clk); s_resp_valid = 1'b0; #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL cap_empty: got ready=%0h out_valid=%0h want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); drive_op(8'd3, 5'd0, 5'd0, 5'd0, 5'd20, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_resp_valid = 1'b1; s_resp_id = 8'd3; s_resp_vd = 64'h55; s_resp_rd = 32'hCAFE; out_ready = 1'b0; #1;
      total++; if (ex_if.resp_ready !== 1'b0 || vrf_we !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold%0d: got resp_ready=%0h vrf_we=%0h want 0 0", i, ex_if.resp_ready, vrf_we); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid%0d: got %0h want 1", i, out_valid); end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    total++; if (vrf_we !== 1'b1 || vrf_waddr !== 5'd20 || vrf_wdata !== 64'h55) begin bad++; $display("[TB] FAIL bp_release: got we=%0h waddr=%0d data=%0h want 1 20 55", vrf_we, vrf_waddr, vrf_wdata); end
    total++; if (out_id !== 8'd3 || out_rd !== 32'hCAFE) begin bad++; $display("[TB] FAIL bp_out: got id=%0d rd=%0h want 3 cafe", out_id, out_rd); end
    @(negedge clk); s_resp_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained: got %0h want 0", out_valid); end
  endtask

  task automatic test_error();
    @(negedge clk); drive_op(8'd2, 5'd0, 5'd0, 5'd0, 5'd21, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); s_resp_valid = 1'b1; s_resp_id = 8'd9; s_resp_vd = 64'h77; #1;
    total++; if (vrf_we !== 1'b1 || vrf_waddr !== 5'd21) begin bad++; $display("[TB] FAIL err_writeback: got we=%0h waddr=%0d want 1 21", vrf_we, vrf_waddr); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_not_yet: got %0h want 0", err); end
    @(negedge clk); s_resp_valid = 1'b0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_set: got %0h want 1", err); end
    @(negedge clk); #1;
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky: got %0h want 1", err); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_op(id_t'(1 + i), 5'd0, 5'd0, 5'd0, vreg_addr_t'(22 + i), 1'b1);
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0; s_resp_valid = 1'b1; s_resp_id = 8'd1; in_vs1 = 5'd22; in_vd = 5'd23; #1;
    total++; if (ex_if.req_valid !== 1'b0 || out_valid !== 1'b0 || vrf_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_flush: got req=%0h out=%0h we=%0h want 0 0 0", ex_if.req_valid, out_valid, vrf_we); end
    total++; if (err !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_state: got err=%0h ready=%0h want 0 1", err, in_ready); end
    @(negedge clk); s_resp_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk); drive_op(8'd7, 5'd22, 5'd23, 5'd24, 5'd23, 1'b1); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_no_stall: got %0h want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    total++; if (ex_if.req_valid !== 1'b1 || ex_if.req_id !== 8'd7) begin bad++; $display("[TB] FAIL rst_issue: got valid=%0h id=%0d want 1 7", ex_if.req_valid, ex_if.req_id); end
    @(negedge clk); s_resp_valid = 1'b1; s_resp_id = 8'd7; #1;
    total++; if (out_id !== 8'd7 || vrf_waddr !== 5'd23 || vrf_we !== 1'b1) begin bad++; $display("[TB] FAIL rst_retire: got id=%0d waddr=%0d we=%0h want 7 23 1", out_id, vrf_waddr, vrf_we); end
    @(negedge clk); s_resp_valid = 1'b0; #1;
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err_clear: got %0h want 0", err); end
  endtask

  task automatic test_err_empty();
    @(negedge clk); s_resp_valid = 1'b1; s_resp_id = 8'd0; #1;
    total++; if (out_valid !== 1'b0 || vrf_we !== 1'b0) begin bad++; $display("[TB] FAIL empty_resp_out: got out=%0h we=%0h want 0 0", out_valid, vrf_we); end
    @(negedge clk); s_resp_valid = 1'b0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL empty_resp_err: got %0h want 1", err); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_raw();
    test_capacity();
    test_backpressure();
    test_error();
    test_reset_midop();
    test_err_empty();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xadac_ex_issuer.md
# xadac_ex_issuer

Initiator (master) end of the `xadac_ex_if` execute interface. Accepts decoded XADAC vector operations from the decoder, reads source vector registers, issues requests to an execution unit (e.g. the vector MAC unit), tracks outstanding operations in order, and retires responses into the vector register file (VRF) and the scalar result channel. Sits between the XADAC decoder/VRF and the execution-unit slaves.

## Interface
Parameters:
- `NrVRegs`, 32: number of vector registers; `vreg_addr_t` is `$clog2(NrVRegs)` bits.
- `MaxOutstanding`, 4: maximum number of in-flight ops (stage B plus tracking FIFO); power of two, ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `in_valid_i` / `in_ready_o`  in/out  1  dispatch handshake.
- `in_id_i`  in  `id_t`  instruction tag.
- `in_imm_i`  in  `imm_t`  immediate, forwarded unchanged.
- `in_vs1_i`, `in_vs2_i`, `in_vs3_i`  in  `vreg_addr_t` each  source register addresses.
- `in_vd_i`  in  `vreg_addr_t`  destination register.
- `in_vd_we_i`  in  1  op writes `vd`.
- `vrf_raddr_o[3]`  out  3×`vreg_addr_t`  VRF read addresses; data returns next cycle.
- `vrf_rdata_i[3]`  in  3×`vec_t`  VRF read data.
- `vrf_we_o`, `vrf_waddr_o`, `vrf_wdata_o`  out  1 / `vreg_addr_t` / `vec_t`  VRF write port.
- `out_valid_o` / `out_ready_i`  out/in  1  result handshake to core.
- `out_id_o`, `out_rd_o`  out  `id_t` / `reg_t`  retired tag and scalar result.
- `err_o`  out  1  sticky protocol error.
- `mst`  `xadac_ex_if.Master`  execute interface (`req_*`, `resp_*`).

## Operation
- Stage B: one register holding {id, imm, vs1..3, vd, vd_we}, plus a valid bit. Dispatch accept (`in_valid_i && in_ready_o`) loads it.
- `vrf_raddr_o` = `in_vs*_i` in an accept cycle, else stage B addresses (held so `vrf_rdata_i` stays valid while stalled).
- `mst.req_valid` = stage B valid; `req_vs1..3` = `vrf_rdata_i[0..2]`; `req_id`, `req_imm` from stage B.
- Tracking FIFO (depth `MaxOutstanding`) of {id, vd, vd_we}; push on `req_valid && req_ready`.
- Scoreboard: `pending[NrVRegs]`; bit `vd` set on dispatch accept when `in_vd_we_i`; cleared on response accept for head.vd when head.vd_we. Set and clear on the same register in one cycle: set wins.
- `in_ready_o` = (!stageB_valid || mst.req_ready) && (fifo_count + stageB_valid < MaxOutstanding) && none of `pending[vs1]`, `pending[vs2]`, `pending[vs3]`, `pending[vd]` set. No bypass; RAW/WAW hazards stall.
- Responses return in issue order. `mst.resp_ready` = `out_ready_i && fifo_nonempty`; `out_valid_o` = `mst.resp_valid && fifo_nonempty`; `out_id_o` = FIFO head id; `out_rd_o` = `mst.resp_rd`.
- Response accept: pop FIFO; `vrf_we_o` = head.vd_we, `vrf_waddr_o` = head.vd, `vrf_wdata_o` = `mst.resp_vd`, combinationally in the same cycle.
- `err_o` sets on response accept with `resp_id != head.id` (writeback still performed), or `resp_valid` while FIFO empty; clears only on reset.

## Timing
- Reset: stage B and FIFO empty, `pending` = 0, `err_o` = 0. All outputs 0 except `in_ready_o` = 1 when `in_valid_i` is low or sources are free.
- Dispatch at cycle T produces `req_valid` at T+1 (min latency 1). Back-to-back issue of independent ops: 1 op/cycle.
- Same-cycle FIFO push and pop allowed. `fifo_count` is not credited by a same-cycle pop when computing `in_ready_o`.
- A zero-latency slave (resp same cycle as req) retires in the push cycle: the FIFO entry is pushed and popped together; the pop takes the entry at the head.
- Reset mid-operation drops all in-flight ops; no VRF writes issue after reset assertion.

## Structure
- `xadac_pkg`: `id_t`, `imm_t`, `vec_t`, `reg_t`, and `VectorWidth`; add `vreg_addr_t` there if not present.
- Sub-module `xadac_issue_fifo`: synchronous FIFO (push/pop/full/empty/count, peek head) for tracking entries.

## Test plan
- Single op: id=5, vs1=1, vs2=2, vs3=3, vd=4, VRF preloaded; zero-latency slave → `req_valid` at T+1 with VRF data; VRF write reg 4 and `out_id_o`=5 in the same cycle.
- RAW: op A vd=7, op B vs1=7 offered the next cycle → `in_ready_o`=0 until A's response retires; B dispatches the cycle after.
- Capacity: slave holds `resp_valid`=0 and `req_ready`=1; 5 independent ops offered → 4 accepted, 5th stalls until the first response is accepted.
- Backpressure: `out_ready_i`=0 for 3 cycles → `mst.resp_ready`=0; no VRF write; FIFO unchanged.
- Error: response id 9 while head id 2 → `err_o`=1 from the next cycle onward; VRF still written to head.vd.
- Reset asserted with 3 ops outstanding → `pending`=0 and FIFO empty; the next op dispatches without a stall.
